// File: rtl/divider_pkg.sv
// Shared types and helpers for the divider scheduler.
// Holds default width, id-width helper and the in-flight tag.
package divider_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int MAX_ID_W  = 3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at ptr.
// Purely combinational; the owner keeps the pointer.
module rr_arbiter
  import divider_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [id_w(NUM_REQ)-1:0]    ptr,
  output logic [NUM_REQ-1:0]          gnt
);

  localparam int IW = id_w(NUM_REQ);

  logic          found;
  int            idx;
  logic [IW-1:0] sel;

  // Walk requesters from ptr upward, wrapping, first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divider_sched.sv
// Shares one pipelined divider among NUM_REQ requesters.
// Round-robin issue, tag pipeline, registered in-order responses.
module divider_sched
  import divider_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_REQ     = 4,
  parameter int DIV_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*2*WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0]     req_divisor,
  output logic [2*WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]             div_divisor,
  input  logic [WIDTH-1:0]             div_quotient,
  input  logic [WIDTH-1:0]             div_remainder,
  input  logic                         div_error_divide_by_zero,
  input  logic                         div_overflow,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]             rsp_quotient,
  output logic [WIDTH-1:0]             rsp_remainder,
  output logic                         rsp_error_divide_by_zero,
  output logic                         rsp_overflow,
  output logic                         busy
);

  localparam int IW = id_w(NUM_REQ);
  localparam int DW = 2 * WIDTH;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gnt_id;
  logic [DW-1:0]      sel_dvd;
  logic [WIDTH-1:0]   sel_dvs;
  logic               fire;

  tag_t iss;
  tag_t pipe [DIV_LATENCY];
  tag_t last;
  logic unused_tag;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign req_ready = rst ? '0 : gnt;
  assign fire      = |req_ready;

  // Encode the grant and select the winner's operands.
  always_comb begin
    gnt_id  = '0;
    sel_dvd = '0;
    sel_dvs = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_id  = IW'(i);
        sel_dvd = req_dividend[i*DW +: DW];
        sel_dvs = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  // Priority pointer moves past the winner only on a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Register operands to the divider and open the tag for them.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss          <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      iss.valid <= fire;
      iss.id    <= MAX_ID_W'(gnt_id);
      if (fire) begin
        div_dividend <= sel_dvd;
        div_divisor  <= sel_dvs;
      end
    end
  end

  // Tag delay line matching the divider latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DIV_LATENCY; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= iss;
      for (int k = 1; k < DIV_LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign last       = pipe[DIV_LATENCY-1];
  assign unused_tag = ^last.id;

  // Capture divider results for the tag leaving the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid                <= 1'b0;
      rsp_id                   <= '0;
      rsp_quotient             <= '0;
      rsp_remainder            <= '0;
      rsp_error_divide_by_zero <= 1'b0;
      rsp_overflow             <= 1'b0;
    end else begin
      rsp_valid <= last.valid;
      if (last.valid) begin
        rsp_id                   <= last.id[IW-1:0];
        rsp_quotient             <= div_quotient;
        rsp_remainder            <= div_remainder;
        rsp_error_divide_by_zero <= div_error_divide_by_zero;
        rsp_overflow             <= div_overflow;
      end
    end
  end

  // Busy while any stage, including the response, holds work.
  always_comb begin
    busy = iss.valid | rsp_valid;
    for (int k = 0; k < DIV_LATENCY; k++) busy = busy | pipe[k].valid;
  end

endmodule
